// File: rtl/phy_rx_pkg.sv
// Shared types and width helpers for the N-lane receive unstriper.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } rx_state_e;

    localparam int MAX_LANES = 8;

    // Pointer width for an index over n items; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phy_rx_unstriping_n_lane_fifo.sv
// Per-lane show-ahead FIFO; a push into a full FIFO is accepted when the head pops that cycle.
module lane_fifo
    import phy_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Storage carries no reset: contents are only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/phy_rx_unstriping_n.sv
// Re-interleaves LANES skewed receive lanes round-robin into a single registered word stream.
module phy_rx_unstriping_n
    import phy_rx_pkg::*;
#(
    parameter int LANES = 2,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LANES-1:0]                  valid_in,
    input  logic [LANES*WIDTH-1:0]            lane_in,
    output logic [WIDTH-1:0]                  data_out,
    output logic                              valid_out,
    output logic                              active,
    output logic [LANES-1:0]                  overflow,
    output logic [ptr_width(LANES)-1:0]       lane_ptr
);
    localparam int PTR_W = ptr_width(LANES);

    rx_state_e        state_q;
    logic [PTR_W-1:0] lane_ptr_q, lane_ptr_d;
    logic [WIDTH-1:0] data_out_q;
    logic             valid_out_q, active_q;
    logic [LANES-1:0] overflow_q, overflow_d;

    logic [LANES-1:0] empty, full, pop;
    logic [WIDTH-1:0] head [LANES];
    logic             pop_any;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign pop[gi] = (state_q == RUN) && (lane_ptr_q == PTR_W'(gi)) && !empty[gi];

            lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (valid_in[gi]),
                .pop   (pop[gi]),
                .din   (lane_in[gi*WIDTH +: WIDTH]),
                .dout  (head[gi]),
                .empty (empty[gi]),
                .full  (full[gi])
            );
        end
    endgenerate

    assign pop_any    = |pop;
    assign overflow_d = overflow_q | (valid_in & full & ~pop);
    assign lane_ptr_d = (lane_ptr_q == PTR_W'(LANES-1)) ? '0 : lane_ptr_q + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            lane_ptr_q  <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            case (state_q)
                IDLE: begin
                    // FIFOs are empty here, so any strobe is an accepted push.
                    if (|valid_in) state_q <= ALIGN;
                end
                ALIGN: begin
                    if (&(~empty)) begin
                        state_q  <= RUN;
                        active_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
            // Strict round-robin: an empty current lane stalls the stream.
            if (pop_any) begin
                data_out_q  <= head[lane_ptr_q];
                valid_out_q <= 1'b1;
                lane_ptr_q  <= lane_ptr_d;
            end else begin
                valid_out_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign active    = active_q;
    assign overflow  = overflow_q;
    assign lane_ptr  = lane_ptr_q;

endmodule

// File: tb/tb_phy_rx_unstriping_n.sv
// Randomized and directed checks of the unstriper against a queue-based reference model.
module tb_phy_rx_unstriping_n;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Two instances: the default 2-lane build and a 4-lane/16-bit/depth-8 build.
    logic [1:0]  vin2;  logic [63:0] lin2;  logic [31:0] dout2; logic vout2, act2;
    logic [1:0]  ovf2;  logic        ptr2;
    logic [3:0]  vin4;  logic [63:0] lin4;  logic [15:0] dout4; logic vout4, act4;
    logic [3:0]  ovf4;  logic [1:0]  ptr4;

    phy_rx_unstriping_n #(.LANES(2), .WIDTH(32), .DEPTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .valid_in(vin2), .lane_in(lin2),
        .data_out(dout2), .valid_out(vout2), .active(act2), .overflow(ovf2), .lane_ptr(ptr2)
    );

    phy_rx_unstriping_n #(.LANES(4), .WIDTH(16), .DEPTH(8)) u_dut4 (
        .clk(clk), .reset(reset), .valid_in(vin4), .lane_in(lin4),
        .data_out(dout4), .valid_out(vout4), .active(act4), .overflow(ovf4), .lane_ptr(ptr4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per lane plus a few scalar facts.
    int          sel, nl, nd;
    logic [31:0] wmask;
    logic [31:0] mq [8][$];
    int          m_stage;           // 0 idle, 1 aligning, 2 running
    int          m_ptr;
    logic        m_valid;
    logic [31:0] m_data;
    logic [7:0]  m_ovf;
    logic [31:0] got [$];
    int          got_cyc [$];
    int          cyc;

    logic [7:0]  s_vin;
    logic [31:0] s_w [8];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mq[i].delete();
        m_stage = 0; m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ovf = '0;
    endtask

    task automatic cycle(input logic rst);
        bit          popping, any_push, all_ne;
        logic [31:0] pw;
        reset = rst;
        vin2 = '0; lin2 = '0; vin4 = '0; lin4 = '0;
        for (int i = 0; i < nl; i++) begin
            if (sel == 2) begin
                vin2[i] = s_vin[i]; lin2[i*32 +: 32] = s_w[i];
            end else begin
                vin4[i] = s_vin[i]; lin4[i*16 +: 16] = s_w[i][15:0];
            end
        end
        if (rst) begin
            model_clear();
        end else begin
            all_ne = 1'b1;
            for (int i = 0; i < nl; i++) if (mq[i].size() == 0) all_ne = 1'b0;
            popping = 1'b0; pw = '0;
            if (m_stage == 2 && mq[m_ptr].size() > 0) begin
                popping = 1'b1;
                pw = mq[m_ptr].pop_front();
            end
            // Popping first frees the slot a same-cycle push into a full lane needs.
            any_push = 1'b0;
            for (int i = 0; i < nl; i++) begin
                if (s_vin[i]) begin
                    if (mq[i].size() < nd) begin
                        mq[i].push_back(s_w[i] & wmask);
                        any_push = 1'b1;
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end
            end
            if (m_stage == 0 && any_push) m_stage = 1;
            else if (m_stage == 1 && all_ne) m_stage = 2;
            m_valid = popping;
            if (popping) begin
                m_data = pw;
                m_ptr  = (m_ptr + 1) % nl;
                got.push_back(pw);
                got_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (sel == 2) begin
            check_val("valid_out", 32'(vout2), 32'(m_valid));
            check_val("data_out",  dout2, m_data);
            check_val("active",    32'(act2), 32'(m_stage == 2));
            check_val("overflow",  32'(ovf2), 32'(m_ovf[1:0]));
            check_val("lane_ptr",  32'(ptr2), 32'(m_ptr));
        end else begin
            check_val("valid_out", 32'(vout4), 32'(m_valid));
            check_val("data_out",  32'(dout4), m_data);
            check_val("active",    32'(act4), 32'(m_stage == 2));
            check_val("overflow",  32'(ovf4), 32'(m_ovf[3:0]));
            check_val("lane_ptr",  32'(ptr4), 32'(m_ptr));
        end
        if (m_valid) $display("cyc %0d lanes=%0d out=%h", cyc, nl, m_data);
        cyc++;
        s_vin = '0;
    endtask

    task automatic idle(input int n);
        s_vin = '0;
        repeat (n) cycle(1'b0);
    endtask

    task automatic set_cfg(input int lanes);
        sel = lanes; nl = lanes;
        nd    = (lanes == 2) ? 4 : 8;
        wmask = (lanes == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        s_vin = '0;
        cycle(1'b1);
        got.delete(); got_cyc.delete();
    endtask

    int skew [4];

    initial begin
        reset = 1'b1; vin2 = '0; lin2 = '0; vin4 = '0; lin4 = '0;
        cyc = 0; s_vin = '0;
        for (int i = 0; i < 8; i++) s_w[i] = '0;
        model_clear();

        // Aligned two-lane stream.
        set_cfg(2);
        s_vin = 8'h3; s_w[0] = 32'hA0; s_w[1] = 32'hA1; cycle(1'b0);
        s_vin = 8'h3; s_w[0] = 32'hA2; s_w[1] = 32'hA3; cycle(1'b0);
        check_val("s1_active_edge1", 32'(act2), 32'd1);
        idle(6);
        check_val("s1_count", got.size(), 32'd4);
        for (int k = 0; k < 4 && k < got.size(); k++) check_val("s1_order", got[k], 32'hA0 + k);

        // Lane 1 skewed by three cycles.
        set_cfg(2);
        for (int c = 0; c < 7; c++) begin
            s_vin = {6'b0, c >= 3, c < 4};
            s_w[0] = $urandom; s_w[1] = $urandom;
            cycle(1'b0);
        end
        idle(6);
        check_val("s2_ovf", 32'(ovf2), 32'd0);

        // Lane 0 overruns its FIFO before lane 1 shows up.
        set_cfg(2);
        for (int k = 0; k < 5; k++) begin
            s_vin = 8'h1; s_w[0] = 32'hB0 + k; cycle(1'b0);
        end
        check_val("s3_ovf_set", 32'(ovf2), 32'd1);
        check_val("s3_still_align", 32'(act2), 32'd0);
        for (int k = 0; k < 4; k++) begin
            s_vin = 8'h2; s_w[1] = 32'hC0 + k; cycle(1'b0);
        end
        idle(8);
        check_val("s3_ovf_sticky", 32'(ovf2), 32'd1);
        check_val("s3_count", got.size(), 32'd8);

        // Ordering stall on lane 1.
        set_cfg(2);
        s_vin = 8'h3; s_w[0] = 32'hD0; s_w[1] = 32'hD1; cycle(1'b0);
        s_vin = 8'h1; s_w[0] = 32'hD2; cycle(1'b0);
        s_vin = 8'h1; s_w[0] = 32'hD4; cycle(1'b0);
        idle(4);
        check_val("s4_stall_ptr", 32'(ptr2), 32'd1);
        check_val("s4_stall_valid", 32'(vout2), 32'd0);
        s_vin = 8'h2; s_w[1] = 32'hD3; cycle(1'b0);
        idle(2);
        s_vin = 8'h2; s_w[1] = 32'hD5; cycle(1'b0);
        idle(4);
        check_val("s4_count", got.size(), 32'd6);
        for (int k = 0; k < 6 && k < got.size(); k++) check_val("s4_order", got[k], 32'hD0 + k);

        // Four lanes with random skew.
        set_cfg(4);
        for (int i = 0; i < 4; i++) skew[i] = $urandom_range(0, 7);
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 4; i++) begin
                s_vin[i] = (c >= skew[i]) && (c < skew[i] + 8);
                s_w[i]   = 32'(32'h1000 * i + (c - skew[i]));
            end
            cycle(1'b0);
        end
        idle(30);
        check_val("s5_count", got.size(), 32'd32);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 4; i++)
                if (k*4 + i < got.size()) check_val("s5_order", got[k*4+i], 32'(32'h1000 * i + k));
        if (got_cyc.size() == 32) check_val("s5_no_gaps", got_cyc[31] - got_cyc[0], 32'd31);
        check_val("s5_ovf", 32'(ovf4), 32'd0);

        // Random traffic with a reset landing mid-stream, then realignment.
        for (int cfg = 2; cfg <= 4; cfg += 2) begin
            set_cfg(cfg);
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < nl; i++) begin
                    s_vin[i] = ($urandom_range(0, 2*nl - 1) == 0);
                    s_w[i]   = $urandom;
                end
                if (c == 120) begin
                    check_val("rnd_in_run", 32'(sel == 2 ? act2 : act4), 32'd1);
                    cycle(1'b1);
                    check_val("rnd_rst_active", 32'(sel == 2 ? act2 : act4), 32'd0);
                    check_val("rnd_rst_valid", 32'(sel == 2 ? vout2 : vout4), 32'd0);
                end else begin
                    cycle($urandom_range(0, 199) == 0);
                end
            end
            idle(20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phy_rx_unstriping_n.md
Name: phy_rx_unstriping_n

Overview:
- Parametrised successor of the two-lane receive unstriper.
- Accepts LANES parallel lanes of WIDTH-bit words, each with its own valid, after per-lane serial-to-parallel and demux.
- Absorbs inter-lane skew with per-lane FIFOs, waits until all lanes hold data, then re-interleaves words round-robin (lane 0, 1, …, LANES-1, 0, …) into one output stream.
- Sits at the tail of the PHY receive path, in the single output clock domain.

Parameters:
- LANES, 2, number of striped lanes (2..8).
- WIDTH, 32, word width per lane and at output.
- DEPTH, 4, per-lane FIFO depth in words; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all logic posedge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  LANES  per-lane word strobe; bit i qualifies lane i.
- lane_in  input  LANES*WIDTH  lane i word at bits [i*WIDTH +: WIDTH].
- data_out  output  WIDTH  unstriped word, registered.
- valid_out  output  1  data_out valid this cycle, registered.
- active  output  1  high while state is RUN.
- overflow  output  LANES  sticky per-lane overflow flag.
- lane_ptr  output  clog2(LANES) (min 1)  lane to be popped next.

Behaviour:
- Reset is synchronous; it has priority over all other events, including mid-operation.
  - Outputs: data_out = 0, valid_out = 0, active = 0, overflow = 0, lane_ptr = 0.
  - All FIFOs empty; state = IDLE.
- Push, per lane i, evaluated every cycle:
  - valid_in[i] with FIFO i not full: write lane_in word i.
  - Full FIFO i with a pop of lane i in the same cycle: push is accepted and count is unchanged.
  - valid_in[i] while full and not popping: word is dropped and overflow[i] is set. It stays set until reset.
- States:
  - IDLE → ALIGN when any FIFO becomes non-empty.
  - ALIGN → RUN at the first clock edge where every FIFO is non-empty, evaluated on pre-push counts.
  - RUN stays RUN until reset; there is no return to IDLE.
  - In IDLE and ALIGN no pops occur; valid_out = 0 and lanes simply fill. Overflow is possible here if skew exceeds DEPTH.
- Pop, RUN only:
  - If FIFO[lane_ptr] is non-empty at an edge: the head is popped, data_out ← head, valid_out ← 1, and lane_ptr ← (lane_ptr+1) mod LANES, wrapping from LANES-1 to 0.
  - If FIFO[lane_ptr] is empty: valid_out ← 0, data_out holds its last value, lane_ptr holds. This is an ordering stall; other lanes are never popped out of turn.
- Latency:
  - A word pushed at edge n is poppable at edge n+1 at the earliest.
  - In RUN with no stall, data_out/valid_out update at edge n+1.
- active: registered; rises at the same edge that enters RUN. The first pop occurs at the following edge.
- Widths:
  - FIFO count is clog2(DEPTH)+1 bits.
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - No arithmetic on data.
- Full throughput requires aggregate input ≤ 1 word/cycle. Sustained higher input fills the FIFOs and raises overflow; this is legal, not an X condition.

Decomposition:
- Package phy_rx_pkg:
  - typedef of the state enum {IDLE, ALIGN, RUN}.
  - localparam for pointer widths, from clog2 of LANES and DEPTH.
- Sub-module lane_fifo, parameters WIDTH and DEPTH:
  - synchronous FIFO with push, pop, din, dout (head, show-ahead), empty, full, and push-while-full-with-pop support.
  - Instantiated LANES times via generate.
- Top level holds the FSM, round-robin pointer, overflow flags and output register.

Test Plan:
- Aligned 2 lanes: lane0 words 0xA0, 0xA2 and lane1 words 0xA1, 0xA3, both arriving cycles 0–1 → active rises at edge 1; data_out 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; lane_ptr 0, 1, 0, 1.
- Skew: lane1 delayed 3 cycles relative to lane0 (LANES=2, DEPTH=4) → no valid_out until lane1's first word lands; output order is still strictly alternating; overflow = 0.
- Overflow: lane0 gets 5 words while lane1 gets none (DEPTH=4) → overflow = 2'b01, the 5th word is lost, state stays ALIGN; overflow persists after lane1 arrives and data flows.
- Stall: in RUN, lane1 FIFO runs empty while lane0 holds 2 words → valid_out drops and lane_ptr stays 1 until a lane1 word arrives, then output resumes in order 1, 0, 1.
- Parametrised run, LANES=4, WIDTH=16, DEPTH=8: each lane i sends 0x1000*i + k for k = 0..7 with random per-lane skew < 8 → output is the round-robin sequence k-major, lane-minor, with no gaps once all lanes are primed.
- Reset mid-stream: assert reset in RUN with FIFOs partially full → the next cycle shows all outputs 0 and state IDLE; fresh traffic realigns correctly.
